// File: rtl/dcs_init_pkg.sv
// Shared definitions for the DCS panel init sequencer: state encoding,
// DSI data types and the fixed command table.
package dcs_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [5:0] DT_SHORT0 = 6'h05;
    localparam logic [5:0] DT_SHORT1 = 6'h15;
    localparam int         NUM_CMDS  = 4;
    localparam int         IDX_W     = 2;

    typedef struct packed {
        logic [5:0] dt;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] dly;
    } cmd_t;

    localparam cmd_t CMD_SLPOUT = '{dt: DT_SHORT0, d0: 8'h11, d1: 8'h00, dly: 8'd120};
    localparam cmd_t CMD_COLMOD = '{dt: DT_SHORT1, d0: 8'h3A, d1: 8'h77, dly: 8'd0};
    localparam cmd_t CMD_MADCTL = '{dt: DT_SHORT1, d0: 8'h36, d1: 8'h00, dly: 8'd0};
    localparam cmd_t CMD_DISPON = '{dt: DT_SHORT0, d0: 8'h29, d1: 8'h00, dly: 8'd0};

    // Display-on hold time is a module parameter, so it is patched in here.
    function automatic cmd_t get_cmd(input logic [IDX_W-1:0] idx, input logic [7:0] hold_ms);
        cmd_t c;
        case (idx)
            2'd0:    c = CMD_SLPOUT;
            2'd1:    c = CMD_COLMOD;
            2'd2:    c = CMD_MADCTL;
            default: begin
                c     = CMD_DISPON;
                c.dly = hold_ms;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dcs_init_seq_ms_timer.sv
// Millisecond delay timer: tick prescaler plus 8-bit ms counter. expired is
// high on the last cycle of a delay_ms*TICKS_PER_MS cycle run.
module ms_timer #(
    parameter int TICKS_PER_MS = 27000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] delay_ms,
    output logic       expired
);

    localparam int             TW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_MS - 1);

    logic [TW-1:0] r_tick;
    logic [7:0]    r_ms;

    assign expired = (delay_ms == 8'd0) ||
                     ((r_ms == delay_ms - 8'd1) && (r_tick == TICK_LAST));

    // Counting freezes once expired so the counters never run past delay_ms.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (clear) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (start && !expired) begin
            if (r_tick == TICK_LAST) begin
                r_tick <= '0;
                r_ms   <= r_ms + 8'd1;
            end else begin
                r_tick <= r_tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/dcs_init_seq.sv
// Panel bring-up sequencer: issues the fixed DCS short-packet list once the
// power sequencer raises hs_start, honouring per-command delays.
import dcs_init_pkg::*;

module dcs_init_seq #(
    parameter int TICKS_PER_MS  = 27000,
    parameter int VIDEO_HOLD_MS = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       hs_start,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [5:0] pkt_dt,
    output logic [7:0] pkt_d0,
    output logic [7:0] pkt_d1,
    output logic       busy,
    output logic       init_done,
    output logic       video_en
);

    state_t           r_state;
    state_t           w_next;
    logic             r_hs_q;
    logic [IDX_W-1:0] r_idx;
    logic             r_pkt_valid;
    logic [5:0]       r_pkt_dt;
    logic [7:0]       r_pkt_d0;
    logic [7:0]       r_pkt_d1;
    logic             r_busy;
    logic             r_init_done;
    logic             r_video_en;

    cmd_t             w_cmd;
    logic             w_rise;
    logic             w_xfer;
    logic             w_last;
    logic             w_expired;

    assign w_cmd  = get_cmd(r_idx, 8'(VIDEO_HOLD_MS));
    assign w_rise = hs_start & ~r_hs_q;
    assign w_xfer = (r_state == ST_SEND) & r_pkt_valid & pkt_ready;
    assign w_last = (r_idx == IDX_W'(NUM_CMDS - 1));

    ms_timer #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_ms_timer (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (w_xfer),
        .start    (r_state == ST_WAIT),
        .delay_ms (w_cmd.dly),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Losing hs_start anywhere outside IDLE aborts the sequence.
    always_comb begin
        w_next = r_state;
        if (r_state != ST_IDLE && !hs_start) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rise) w_next = ST_LOAD;
                ST_LOAD: w_next = ST_SEND;
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_cmd.dly != 8'd0) w_next = ST_WAIT;
                        else                   w_next = w_last ? ST_DONE : ST_LOAD;
                    end
                end
                ST_WAIT: if (w_expired) w_next = w_last ? ST_DONE : ST_LOAD;
                ST_DONE: w_next = ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hs_q      <= 1'b0;
            r_idx       <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_dt    <= '0;
            r_pkt_d0    <= '0;
            r_pkt_d1    <= '0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_video_en  <= 1'b0;
        end else begin
            r_hs_q <= hs_start;
            if (w_next == ST_IDLE) begin
                r_pkt_valid <= 1'b0;
                r_pkt_dt    <= '0;
                r_pkt_d0    <= '0;
                r_pkt_d1    <= '0;
                r_busy      <= 1'b0;
                r_init_done <= 1'b0;
                r_video_en  <= 1'b0;
            end else begin
                if (r_state == ST_IDLE) begin
                    r_idx  <= '0;
                    r_busy <= 1'b1;
                end
                if (r_state == ST_LOAD) begin
                    r_pkt_valid <= 1'b1;
                    r_pkt_dt    <= w_cmd.dt;
                    r_pkt_d0    <= w_cmd.d0;
                    r_pkt_d1    <= w_cmd.d1;
                end
                if (w_xfer) r_pkt_valid <= 1'b0;
                if (w_next == ST_LOAD && (r_state == ST_SEND || r_state == ST_WAIT))
                    r_idx <= r_idx + IDX_W'(1);
                if (w_next == ST_DONE) begin
                    r_busy      <= 1'b0;
                    r_init_done <= 1'b1;
                    r_video_en  <= 1'b1;
                end
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_dt    = r_pkt_dt;
    assign pkt_d0    = r_pkt_d0;
    assign pkt_d1    = r_pkt_d1;
    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign video_en  = r_video_en;

endmodule

// File: tb/tb_dcs_init_seq.sv
// Directed bench for dcs_init_seq with a 10-tick millisecond and 20 ms
// display-on hold; a negedge monitor logs transfers and their cycle numbers.
module tb_dcs_init_seq;

    localparam int TPM = 10;
    localparam int VH  = 20;

    localparam logic [21:0] P11 = {6'h05, 8'h11, 8'h00};
    localparam logic [21:0] P3A = {6'h15, 8'h3A, 8'h77};
    localparam logic [21:0] P36 = {6'h15, 8'h36, 8'h00};
    localparam logic [21:0] P29 = {6'h05, 8'h29, 8'h00};

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       hs_start  = 1'b0;
    logic       pkt_ready = 1'b0;
    logic       pkt_valid;
    logic [5:0] pkt_dt;
    logic [7:0] pkt_d0;
    logic [7:0] pkt_d1;
    logic       busy;
    logic       init_done;
    logic       video_en;

    logic [25:0] all_outs;
    logic [21:0] cur_pkt;
    assign all_outs = {pkt_valid, pkt_dt, pkt_d0, pkt_d1, busy, init_done, video_en};
    assign cur_pkt  = {pkt_dt, pkt_d0, pkt_d1};

    int n_tests = 0;
    int n_fail  = 0;

    dcs_init_seq #(
        .TICKS_PER_MS  (TPM),
        .VIDEO_HOLD_MS (VH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .hs_start  (hs_start),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_dt    (pkt_dt),
        .pkt_d0    (pkt_d0),
        .pkt_d1    (pkt_d1),
        .busy      (busy),
        .init_done (init_done),
        .video_en  (video_en)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          acc_cyc[$];
    logic [21:0] acc_pkt[$];
    int          vld_rise[$];
    int          vid_cyc = -1;
    logic        prev_vld = 1'b0;
    logic        prev_vid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (pkt_valid && !prev_vld) vld_rise.push_back(cyc);
        if (pkt_valid && pkt_ready) begin
            acc_cyc.push_back(cyc);
            acc_pkt.push_back(cur_pkt);
        end
        if (video_en && !prev_vid) vid_cyc = cyc;
        prev_vld = pkt_valid;
        prev_vid = video_en;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        acc_cyc.delete();
        acc_pkt.delete();
        vld_rise.delete();
        vid_cyc = -1;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          bad;
        logic [21:0] snap;
        logic [21:0] first;

        // Reset state, then idle with hs_start low
        pkt_ready = 1'b1;
        #12;
        check_val("reset_outs", 32'(all_outs), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val("idle_outs", 32'(all_outs), 32'd0);

        // Full sequence, ready tied high
        clear_log();
        hs_start = 1'b1;
        next_neg();
        check_val("lat_edge1_vld", 32'(pkt_valid), 32'd0);
        check_val("lat_edge1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("lat_edge2_vld", 32'(pkt_valid), 32'd1);
        check_val("first_pkt", 32'(cur_pkt), 32'(P11));
        for (int i = 0; i < 3000 && !video_en; i++) @(negedge clk);
        #1;
        check_val("seq_video_en", 32'(video_en), 32'd1);
        check_val("seq_init_done", 32'(init_done), 32'd1);
        check_val("seq_busy_low", 32'(busy), 32'd0);
        check_val("seq_n_pkts", 32'(acc_pkt.size()), 32'd4);
        check_val("seq_n_vld", 32'(vld_rise.size()), 32'd4);
        if (acc_pkt.size() == 4 && vld_rise.size() == 4) begin
            check_val("seq_pkt0", 32'(acc_pkt[0]), 32'(P11));
            check_val("seq_pkt1", 32'(acc_pkt[1]), 32'(P3A));
            check_val("seq_pkt2", 32'(acc_pkt[2]), 32'(P36));
            check_val("seq_pkt3", 32'(acc_pkt[3]), 32'(P29));
            // Transfer edge, then WAIT for N cycles, LOAD, SEND: next valid N+2 samples later
            check_val("gap_after_11", 32'(vld_rise[1] - acc_cyc[0]), 32'(120 * TPM + 2));
            check_val("gap_after_3a", 32'(vld_rise[2] - acc_cyc[1]), 32'd2);
            check_val("gap_after_36", 32'(vld_rise[3] - acc_cyc[2]), 32'd2);
            check_val("video_after_29", 32'(vid_cyc - acc_cyc[3]), 32'(VH * TPM + 1));
        end

        // Hold hs_start high after DONE: no restart
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!init_done || !video_en || pkt_valid || busy) bad++;
        end
        #1;
        check_val("hold_done_stable", 32'(bad), 32'd0);
        check_val("hold_no_new_pkt", 32'(vld_rise.size()), 32'd4);

        // Drop from DONE, restart, then abort mid-WAIT after 0x11
        @(posedge clk); #1 hs_start = 1'b0;
        next_neg();
        check_val("drop_done_outs", 32'(all_outs), 32'd0);
        @(posedge clk); #1 clear_log();
        hs_start = 1'b1;
        for (int i = 0; i < 10 && acc_pkt.size() == 0; i++) @(negedge clk);
        #1;
        check_val("restart_n_acc", 32'(acc_pkt.size()), 32'd1);
        first = (acc_pkt.size() > 0) ? acc_pkt[0] : 22'd0;
        check_val("restart_pkt", 32'(first), 32'(P11));
        repeat (100) @(negedge clk);
        check_val("mid_wait_busy", 32'(busy), 32'd1);
        check_val("mid_wait_vld", 32'(pkt_valid), 32'd0);
        @(posedge clk); #1 hs_start = 1'b0;
        next_neg();
        check_val("abort_outs", 32'(all_outs), 32'd0);
        @(posedge clk); #1 clear_log();
        hs_start = 1'b1;
        next_neg();
        @(negedge clk);
        check_val("abort_restart_vld", 32'(pkt_valid), 32'd1);
        check_val("abort_restart_pkt", 32'(cur_pkt), 32'(P11));

        // Back-pressure: ready low for 50 cycles in SEND
        @(posedge clk); #1 hs_start = 1'b0;
        pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 clear_log();
        hs_start = 1'b1;
        next_neg();
        @(negedge clk);
        check_val("stall_vld", 32'(pkt_valid), 32'd1);
        snap = cur_pkt;
        bad  = 0;
        repeat (50) begin
            @(negedge clk);
            if (!pkt_valid || cur_pkt !== snap) bad++;
        end
        check_val("stall_stable", 32'(bad), 32'd0);
        check_val("stall_pkt", 32'(snap), 32'(P11));
        check_val("stall_no_acc", 32'(acc_pkt.size()), 32'd0);
        @(posedge clk); #1 pkt_ready = 1'b1;
        @(posedge clk); #1 pkt_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_val("release_one_xfer", 32'(acc_pkt.size()), 32'd1);
        check_val("release_vld_low", 32'(pkt_valid), 32'd0);

        // Async reset while 0x3A is stalled in SEND, release with hs_start high
        for (int i = 0; i < 1400 && vld_rise.size() < 2; i++) @(negedge clk);
        #1;
        check_val("pre_rst_vld", 32'(pkt_valid), 32'd1);
        check_val("pre_rst_pkt", 32'(cur_pkt), 32'(P3A));
        #2 resetn = 1'b0;
        #1;
        check_val("async_rst_outs", 32'(all_outs), 32'd0);
        @(posedge clk); #1 clear_log();
        pkt_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        next_neg();
        check_val("rst_rel_edge1_vld", 32'(pkt_valid), 32'd0);
        check_val("rst_rel_edge1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("rst_rel_vld", 32'(pkt_valid), 32'd1);
        check_val("rst_rel_pkt", 32'(cur_pkt), 32'(P11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
